// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: default datapath width and divider state encoding.
package multdiv_pkg;

  localparam int unsigned MD_WIDTH = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StRun   = ST_RUN,
    StFixup = ST_FIXUP,
    StDone  = ST_DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {A,Q} left, trial-subtract M, restore on borrow.
module div_step
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] next_a_o,
  output logic [WIDTH-1:0] next_q_o
);

  logic [WIDTH:0]   a_sh;
  logic [WIDTH+1:0] trial;
  logic             unused_trial_bit;

  // Shifted A can reach 2^(WIDTH+1)-1, so the trial difference carries an extra sign bit.
  always_comb begin
    a_sh  = {a_i, q_i[WIDTH-1]};
    trial = {1'b0, a_sh} + {2'b11, ~m_i} + {{(WIDTH+1){1'b0}}, 1'b1};
    if (!trial[WIDTH+1]) begin
      next_a_o = trial[WIDTH-1:0];
      next_q_o = {q_i[WIDTH-2:0], 1'b1};
    end else begin
      next_a_o = a_sh[WIDTH-1:0];
      next_q_o = {q_i[WIDTH-2:0], 1'b0};
    end
  end

  // A non-negative trial is below M, so this bit is always zero when it is used.
  assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/param_div_unit.sv
// Iterative signed/unsigned restoring divider with valid/ready handshake on both sides.
module param_div_unit
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int unsigned      CNT_W  = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, ovf_pend_q, ovf_pend_d;
  logic             div_zero_q, div_zero_d, overflow_q, overflow_d;
  logic             accept, dvs_zero;
  logic [WIDTH-1:0] dvd_abs, dvs_abs, step_a, step_q;

  assign accept   = in_valid & in_ready;
  assign dvs_zero = (divisor == '0);
  // |MIN| wraps back to MIN, which is exactly 2^(WIDTH-1) read as unsigned.
  assign dvd_abs  = (in_signed & dividend[WIDTH-1]) ? (~dividend + One) : dividend;
  assign dvs_abs  = (in_signed & divisor[WIDTH-1]) ? (~divisor + One) : divisor;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .a_i     (a_q),
    .q_i     (q_q),
    .m_i     (m_q),
    .next_a_o(step_a),
    .next_q_o(step_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = dvs_zero ? StDone : StRun;
      StRun:   if (cnt_q == CNT_W'(1)) state_d = StFixup;
      StFixup: state_d = StDone;
      StDone: begin
        if (accept)         state_d = dvs_zero ? StDone : StRun;
        else if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    out_valid = (state_q == StDone);
    quotient  = quotient_q;
    remainder = remainder_q;
    div_zero  = div_zero_q;
    overflow  = overflow_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    ovf_pend_d  = ovf_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;
    if (accept) begin
      cnt_d      = CNT_W'(WIDTH);
      a_d        = '0;
      q_d        = dvd_abs;
      m_d        = dvs_abs;
      q_neg_d    = in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg_d    = in_signed & dividend[WIDTH-1];
      ovf_pend_d = in_signed & (dividend == MinVal) & (divisor == '1);
      div_zero_d = dvs_zero;
      overflow_d = 1'b0;
      if (dvs_zero) begin
        quotient_d  = '1;
        remainder_d = dividend;
      end
    end else if (state_q == StRun) begin
      cnt_d = cnt_q - CNT_W'(1);
      a_d   = step_a;
      q_d   = step_q;
    end else if (state_q == StFixup) begin
      quotient_d  = q_neg_q ? (~q_q + One) : q_q;
      remainder_d = r_neg_q ? (~a_q + One) : a_q;
      overflow_d  = ovf_pend_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      ovf_pend_q  <= ovf_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule
